cpu_phase_seq: RTL and testbench

//  Parametrised instruction sequencer for the cpu15 family; replaces the free-running clock-divider phase

---
 rtl/cpu_phase_seq.sv | 115 +++++++++++
 tb/tb_cpu_phase_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_seq.sv
// rtl/cpu_phase_seq.sv - cpu15 instruction sequencer: FT/DC/EX/WB phase enables, PC, IR, run/step/halt control
module cpu_phase_seq #(
  parameter int                   PC_WIDTH     = 8,
  parameter int                   INSTR_WIDTH  = 15,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int                   FETCH_WAIT   = 0,
  parameter int                   RET_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  input  logic                   step,
  input  logic                   stall,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   halt_req,
  input  logic [INSTR_WIDTH-1:0] prom_data,
  output logic [PC_WIDTH-1:0]    prom_addr,
  output logic [PC_WIDTH-1:0]    p_count,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic                   en_ft,
  output logic                   en_dc,
  output logic                   en_ex,
  output logic                   en_wb,
  output logic                   halted,
  output logic [RET_WIDTH-1:0]   retired
);

  typedef enum logic [2:0] {S_IDLE, S_FT, S_DC, S_EX, S_WB, S_HALT} state_t;

  localparam logic [1:0] FW = 2'(FETCH_WAIT);

  state_t                state, state_nxt;
  logic [1:0]            wait_cnt;
  logic                  step_flag;
  logic                  jump_lat;
  logic                  halt_lat;
  logic [PC_WIDTH-1:0]   jump_addr_lat;

  assign prom_addr = p_count;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run || step) state_nxt = S_FT;
      S_FT:   if (wait_cnt == FW) state_nxt = S_DC;
      S_DC:   state_nxt = S_EX;
      S_EX:   if (!stall) state_nxt = S_WB;
      S_WB: begin
        if (halt_lat)                 state_nxt = S_HALT;
        else if (step_flag || !run)   state_nxt = S_IDLE;
        else                          state_nxt = S_FT;
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Enables are a registered decode of the next state so they are high exactly while in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      step_flag     <= 1'b0;
      jump_lat      <= 1'b0;
      halt_lat      <= 1'b0;
      jump_addr_lat <= '0;
      p_count       <= RESET_VECTOR;
      instr         <= '0;
      retired       <= '0;
      en_ft         <= 1'b0;
      en_dc         <= 1'b0;
      en_ex         <= 1'b0;
      en_wb         <= 1'b0;
      halted        <= 1'b0;
    end else begin
      state  <= state_nxt;
      en_ft  <= (state_nxt == S_FT);
      en_dc  <= (state_nxt == S_DC);
      en_ex  <= (state_nxt == S_EX);
      en_wb  <= (state_nxt == S_WB);
      halted <= (state_nxt == S_HALT);
      case (state)
        S_IDLE: begin
          wait_cnt <= '0;
          if (!run && step) step_flag <= 1'b1;
        end
        S_FT: begin
          if (wait_cnt == FW) begin
            instr    <= prom_data;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_EX: begin
          // Only the releasing cycle is sampled; values seen while stalled are discarded.
          if (!stall) begin
            jump_lat      <= jump_en;
            jump_addr_lat <= jump_addr;
            halt_lat      <= halt_req;
          end
        end
        S_WB: begin
          p_count   <= jump_lat ? jump_addr_lat : p_count + PC_WIDTH'(1);
          retired   <= retired + RET_WIDTH'(1);
          step_flag <= 1'b0;
          wait_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_phase_seq.sv
// tb/tb_cpu_phase_seq.sv - randomized scoreboard bench for cpu_phase_seq with instruction-level reference model
module tb_cpu_phase_seq;
  localparam int FW = 2;

  logic        clk = 1'b0;
  logic        rst_n, run, step, stall, jump_en, halt_req;
  logic [7:0]  jump_addr;
  logic [14:0] prom_data;
  logic [7:0]  prom_addr, p_count;
  logic [14:0] instr;
  logic        en_ft, en_dc, en_ex, en_wb, halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  cpu_phase_seq #(
    .PC_WIDTH(8), .INSTR_WIDTH(15), .RESET_VECTOR(8'h00), .FETCH_WAIT(FW), .RET_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .stall(stall),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req),
    .prom_data(prom_data), .prom_addr(prom_addr), .p_count(p_count), .instr(instr),
    .en_ft(en_ft), .en_dc(en_dc), .en_ex(en_ex), .en_wb(en_wb),
    .halted(halted), .retired(retired)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [14:0] ins;
    int          ex_len;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  logic [14:0] prom [256];
  logic [7:0]  pc_m;
  logic [15:0] ret_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // PROM with FW wait states: data is only correct on the last FT cycle.
  int   age = 0;
  logic prev_ft = 1'b0;
  always @(negedge clk) begin
    if (en_ft) age = prev_ft ? age + 1 : 0;
    prev_ft = en_ft;
    if (en_ft && age == FW) prom_data = prom[prom_addr];
    else prom_data = prom[prom_addr] ^ 15'($urandom_range(1, 32767));
  end

  // Monitor: phase lengths and retirement checked against the scoreboard at every WB.
  int   ft_cnt = 0, dc_cnt = 0, ex_cnt = 0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (!rst_n) begin
      ft_cnt = 0; dc_cnt = 0; ex_cnt = 0;
    end else begin
      check("onehot", 32'($countones({en_ft, en_dc, en_ex, en_wb}) <= 1), 32'd1);
      if (en_ft) ft_cnt++;
      if (en_dc) dc_cnt++;
      if (en_ex) ex_cnt++;
      if (en_wb) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL wb_unexpected: got WB at pc %0h expected none", p_count);
        end else begin
          e_mon = sb.pop_front();
          check("wb_pc", 32'(p_count), 32'(e_mon.pc));
          check("wb_instr", 32'(instr), 32'(e_mon.ins));
          check("ex_len", 32'(ex_cnt), 32'(e_mon.ex_len));
          check("ft_len", 32'(ft_cnt), 32'(FW + 1));
          check("dc_len", 32'(dc_cnt), 32'd1);
          check("wb_retired", 32'(retired), 32'(e_mon.ret));
        end
        ft_cnt = 0; dc_cnt = 0; ex_cnt = 0;
      end
    end
  end

  task automatic wait_ex(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (en_ex) ok = 1'b1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL ex_timeout: got no EX in 200 cycles expected EX");
    end
  endtask

  task automatic do_instr(input int s, input bit jmp, input logic [7:0] addr, input bit hlt,
                          input bit drop_run, input bit step_mid);
    bit   ok;
    exp_t e;
    wait_ex(ok);
    if (!ok) return;
    e.pc = pc_m; e.ins = prom[pc_m]; e.ex_len = s + 1; e.ret = ret_m;
    sb.push_back(e);
    pc_m  = jmp ? addr : pc_m + 8'd1;
    ret_m = ret_m + 16'd1;
    for (int i = 0; i < s; i++) begin
      stall = 1'b1; jump_en = 1'($urandom_range(0, 1)); jump_addr = 8'($urandom);
      halt_req = 1'($urandom_range(0, 1)); step = step_mid && (i == 0);
      @(negedge clk);
    end
    stall = 1'b0; jump_en = jmp; jump_addr = jmp ? addr : 8'($urandom); halt_req = hlt;
    step = step_mid && (s == 0);
    if (drop_run) run = 1'b0;
    @(negedge clk);
    jump_en = 1'b0; halt_req = 1'b0; step = 1'b0; jump_addr = 8'($urandom);
  endtask

  task automatic expect_idle(input int n);
    bit any = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (en_ft | en_dc | en_ex | en_wb) any = 1'b1;
    end
    check("idle_no_enables", 32'(any), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(p_count), 32'h0);
    check({tag, "_prom_addr"}, 32'(prom_addr), 32'h0);
    check({tag, "_instr"}, 32'(instr), 32'h0);
    check({tag, "_halted"}, 32'(halted), 32'h0);
    check({tag, "_retired"}, 32'(retired), 32'h0);
    check({tag, "_enables"}, 32'({en_ft, en_dc, en_ex, en_wb}), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit bad;
    for (int i = 0; i < 256; i++) prom[i] = 15'($urandom);
    rst_n = 1'b0; run = 1'b0; step = 1'b0; stall = 1'b0;
    jump_en = 1'b0; jump_addr = 8'h00; halt_req = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    expect_idle(5);
    pc_m = 8'h00; ret_m = 16'h0;

    run = 1'b1;
    for (int k = 0; k < 30; k++)
      do_instr(($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 5)),
               ($urandom_range(0, 3) == 0), 8'($urandom), 1'b0, 1'b0, 1'b0);

    // Walk across the 0xFF -> 0x00 boundary, then stop at the instruction boundary.
    do_instr(0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    do_instr(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_instr(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_instr(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_idle(8);
    check("stop_pc", 32'(p_count), 32'(pc_m));
    check("stop_retired", 32'(retired), 32'(ret_m));

    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      do_instr(int'($urandom_range(0, 3)), ($urandom_range(0, 1) != 0), 8'($urandom),
               1'b0, 1'b0, (k == 1));
      expect_idle(6);
    end
    check("step_retired", 32'(retired), 32'(ret_m));

    // Halt combined with jump: PC takes the target, then stays halted.
    run = 1'b1;
    do_instr(1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("halted", 32'(halted), 32'd1);
    check("halt_pc", 32'(p_count), 32'h5A);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      run = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (en_ft | en_dc | en_ex | en_wb | !halted || p_count != 8'h5A) bad = 1'b1;
    end
    step = 1'b0;
    check("halt_frozen", 32'(bad), 32'd0);
    check("halt_retired", 32'(retired), 32'(ret_m));

    rst_n = 1'b0;
    #1;
    check("halt_reset_pc", 32'(p_count), 32'h0);
    check("halt_reset_halted", 32'(halted), 32'h0);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    run = 1'b1; rst_n = 1'b1;
    pc_m = 8'h00; ret_m = 16'h0;
    for (int k = 0; k < 3; k++)
      do_instr(int'($urandom_range(0, 2)), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset asserted mid-EX: outputs return to reset values without waiting for a clock.
    wait_ex(ok);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("ex_reset");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    expect_idle(3);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
